alu_status_stage: RTL
=====================

Name: alu_status_stage

Overview:
- Pipeline stage directly downstream of the 16-bit adder/flag generator.
- Captures the adder result and its five status flags (sign, zero, overflow, carry, parity) into a registered status word, behind a valid/ready handshake.
- Provides a sticky overflow flag, a saturating overflow event counter, and a 16-way condition-code evaluator for branch/select logic further downstream.

Parameters:
- DATA_W, 16, result width; must match the adder width.
- OVF_CNT_W, 8, width of the saturating overflow event counter.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  upstream result/flags valid
- in_ready  out  1  stage can accept; equals (~out_valid | out_ready)
- in_z  in  DATA_W  adder result
- in_sign, in_zero, in_overflow, in_carry, in_parity  in  1 each  adder flags (parity=1 means even number of ones)
- out_valid  out  1  registered word valid
- out_ready  in  1  downstream accepts
- out_z  out  DATA_W  registered result
- out_flags  out  5  {sign, zero, overflow, carry, parity}, registered
- cond_sel  in  4  condition select
- cond_true  out  1  selected condition evaluated on out_flags (combinational)
- sticky_ovf  out  1  set by any accepted overflow
- ovf_count  out  OVF_CNT_W  accepted-overflow count, saturating
- clr_sticky  in  1  clears sticky_ovf and ovf_count

Behaviour:
- Reset (async, rst_n=0):
  - out_valid=0, out_z=0, out_flags=0, sticky_ovf=0, ovf_count=0.
  - Reset mid-transfer drops the held word; no partial state survives.
- Accept = in_valid & in_ready.
- On accept:
  - out_z/out_flags load the inputs next edge; out_valid=1.
  - Latency 1 cycle; full throughput with back-to-back accepts when out_ready=1.
- out_valid=1 & out_ready=0:
  - in_ready=0; out_z/out_flags hold stable.
- out_valid=1 & out_ready=1 & no accept:
  - out_valid falls to 0; out_z/out_flags hold their last values (not cleared).
- cond_true is evaluated from out_flags regardless of out_valid. Encoding (S=sign, Z=zero, V=overflow, C=carry, P=parity):
  - 0 EQ: Z
  - 1 NE: ~Z
  - 2 CS: C
  - 3 CC: ~C
  - 4 MI: S
  - 5 PL: ~S
  - 6 VS: V
  - 7 VC: ~V
  - 8 HI: C & ~Z
  - 9 LS: ~C | Z
  - 10 GE: S==V
  - 11 LT: S!=V
  - 12 GT: ~Z & (S==V)
  - 13 LE: Z | (S!=V)
  - 14 PE: P
  - 15 AL: 1
- sticky_ovf:
  - Set on an accept with in_overflow=1.
  - Cleared by clr_sticky.
  - Simultaneous clr_sticky and overflow accept: set wins, sticky_ovf=1.
- ovf_count:
  - +1 per accept with in_overflow=1; saturates at all-ones (no wrap).
  - clr_sticky clears it to 0.
  - Simultaneous clr_sticky and overflow accept: ovf_count=1.
- Flags pass through unmodified; the stage never recomputes them, except in the optional check below.

Optional Feature:
- Macro: ALU_STATUS_FLAG_CHECK_EN.
- When defined:
  - Adds output flag_err (1 bit, reset 0).
  - On each accept, registers flag_err = (in_zero != ~|in_z) | (in_sign != in_z[DATA_W-1]) | (in_parity != ~^in_z).
  - flag_err is aligned with out_flags and held until the next accept.
- When undefined: port and logic are absent; stage behaviour is otherwise identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with out_valid=1 -> out_valid=0, out_flags=5'b0, ovf_count=0, sticky_ovf=0 immediately (async).
- Throughput: in_z=16'h0000 {S0,Z1,V0,C1,P1}, then in_z=16'h8000 {S1,Z0,V1,C0,P0}, out_ready=1 -> out_valid high two consecutive cycles, words in order; cond_sel=0 true on first, cond_sel=11 (LT) false on second (S==V).
- Backpressure: out_ready=0 with out_valid=1 -> in_ready=0, out_z holds 16'h1234 for 5 cycles despite in_valid=1 with 16'hFFFF; release -> 16'hFFFF follows one cycle later.
- Conditions: flags {S1,Z0,V0,C0,P1} -> cond 11 (LT)=1, 12 (GT)=0, 13 (LE)=1, 14 (PE)=1, 15 (AL)=1, 8 (HI)=0.
- Sticky/counter: with OVF_CNT_W=2, 5 overflow accepts -> ovf_count=3 (saturated), sticky_ovf=1; clr_sticky together with a 6th overflow accept -> ovf_count=1, sticky_ovf=1.
- Flag check (ALU_STATUS_FLAG_CHECK_EN defined): in_z=16'h0000 with in_zero=0 -> flag_err=1; next accept of 16'h0003 {S0,Z0,P1} -> flag_err=0.

Source files
------------

// File: rtl/alu_status_stage.sv
// Registered status stage behind the 16-bit adder: holds result and flags behind valid/ready,
// tracks sticky overflow and a saturating overflow count, and evaluates condition codes.
// Optional ALU_STATUS_FLAG_CHECK_EN adds a flag_err output that cross-checks zero/sign/parity.
module alu_status_stage #(
  parameter int DATA_W    = 16,
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DATA_W-1:0]    in_z,
  input  logic                 in_sign,
  input  logic                 in_zero,
  input  logic                 in_overflow,
  input  logic                 in_carry,
  input  logic                 in_parity,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [DATA_W-1:0]    out_z,
  output logic [4:0]           out_flags,
  input  logic [3:0]           cond_sel,
  output logic                 cond_true,
  output logic                 sticky_ovf,
  output logic [OVF_CNT_W-1:0] ovf_count,
  input  logic                 clr_sticky
`ifdef ALU_STATUS_FLAG_CHECK_EN
  ,
  output logic                 flag_err
`endif
);

  typedef enum logic [3:0] {
    CC_EQ = 4'd0,  CC_NE = 4'd1,  CC_CS = 4'd2,  CC_CC = 4'd3,
    CC_MI = 4'd4,  CC_PL = 4'd5,  CC_VS = 4'd6,  CC_VC = 4'd7,
    CC_HI = 4'd8,  CC_LS = 4'd9,  CC_GE = 4'd10, CC_LT = 4'd11,
    CC_GT = 4'd12, CC_LE = 4'd13, CC_PE = 4'd14, CC_AL = 4'd15
  } cond_e;

  logic accept;
  logic ovf_event;
  logic f_s, f_z, f_v, f_c, f_p;

  assign in_ready  = ~out_valid | out_ready;
  assign accept    = in_valid & in_ready;
  assign ovf_event = accept & in_overflow;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_z     <= '0;
      out_flags <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_z     <= in_z;
        out_flags <= {in_sign, in_zero, in_overflow, in_carry, in_parity};
      end else if (out_ready) begin
        // Word consumed with nothing behind it; data is kept for observation.
        out_valid <= 1'b0;
      end
    end
  end

  // An overflow accept in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_ovf <= 1'b0;
      ovf_count  <= '0;
    end else if (clr_sticky) begin
      sticky_ovf <= ovf_event;
      ovf_count  <= ovf_event ? OVF_CNT_W'(1) : '0;
    end else if (ovf_event) begin
      sticky_ovf <= 1'b1;
      if (!(&ovf_count)) ovf_count <= ovf_count + OVF_CNT_W'(1);
    end
  end

`ifdef ALU_STATUS_FLAG_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_err <= 1'b0;
    end else if (accept) begin
      flag_err <= (in_zero != ~|in_z) | (in_sign != in_z[DATA_W-1]) | (in_parity != ~^in_z);
    end
  end
`endif

  assign {f_s, f_z, f_v, f_c, f_p} = out_flags;

  // NOTE: cond_true gets a default first so no path through the case can infer a latch.
  always_comb begin
    cond_true = 1'b0;
    unique case (cond_e'(cond_sel))
      CC_EQ: cond_true = f_z;
      CC_NE: cond_true = ~f_z;
      CC_CS: cond_true = f_c;
      CC_CC: cond_true = ~f_c;
      CC_MI: cond_true = f_s;
      CC_PL: cond_true = ~f_s;
      CC_VS: cond_true = f_v;
      CC_VC: cond_true = ~f_v;
      CC_HI: cond_true = f_c & ~f_z;
      CC_LS: cond_true = ~f_c | f_z;
      CC_GE: cond_true = (f_s == f_v);
      CC_LT: cond_true = (f_s != f_v);
      CC_GT: cond_true = ~f_z & (f_s == f_v);
      CC_LE: cond_true = f_z | (f_s != f_v);
      CC_PE: cond_true = f_p;
      CC_AL: cond_true = 1'b1;
      default: cond_true = 1'b0;
    endcase
  end

endmodule
